// File: rtl/pong_game_ctrl_pkg.sv
// Shared encodings for the pong_2p game-flow controller: FSM states,
// text-region enable bit positions and winner codes.
package pong_pkg;

  typedef enum logic [1:0] {
    NEWGAME = 2'b00,
    PLAY    = 2'b01,
    NEWBALL = 2'b10,
    OVER    = 2'b11
  } state_t;

  localparam int unsigned TEXT_SCORE = 3;
  localparam int unsigned TEXT_LOGO  = 2;
  localparam int unsigned TEXT_RULE  = 1;
  localparam int unsigned TEXT_OVER  = 0;

  localparam logic WIN_BLUE = 1'b0;
  localparam logic WIN_RED  = 1'b1;

  // Text regions shown while the FSM sits in a given state.
  function automatic logic [3:0] text_mask(state_t s);
    logic [3:0] m;
    m = '0;
    m[TEXT_SCORE] = 1'b1;
    case (s)
      NEWGAME: begin
        m[TEXT_LOGO] = 1'b1;
        m[TEXT_RULE] = 1'b1;
      end
      OVER:    m[TEXT_OVER] = 1'b1;
      default: ;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/pong_game_ctrl_if.sv
// Bundle between the game-flow controller and its neighbours: miss/start/tick
// inputs from the graphics side, score and text-control outputs to the overlay.
interface pong_game_ctrl_if;
  logic       refresh_tick;
  logic       start_btn;
  logic       left_miss;
  logic       right_miss;
  logic [3:0] ball;
  logic [3:0] left_score;
  logic [3:0] right_score;
  logic       winner;
  logic [3:0] text_en;
  logic       gra_still;

  modport master (
    output refresh_tick, start_btn, left_miss, right_miss,
    input  ball, left_score, right_score, winner, text_en, gra_still
  );

  modport slave (
    input  refresh_tick, start_btn, left_miss, right_miss,
    output ball, left_score, right_score, winner, text_en, gra_still
  );
endinterface

// File: rtl/pong_game_ctrl_timer.sv
// Frame-tick down-counter used for the NEWBALL and OVER pauses.
module pong_timer #(
  parameter int unsigned TIMER_TICKS = 120
) (
  input  logic clk,
  input  logic reset_n,
  input  logic load,
  input  logic tick,
  output logic timer_up
);

  localparam int unsigned W = $clog2(TIMER_TICKS + 1);

  logic [W-1:0] count;

  // Load wins over tick, so a tick landing on the load cycle is not counted.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= W'(TIMER_TICKS);
    end else if (tick && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign timer_up = (count == '0);

endmodule

// File: rtl/pong_game_ctrl.sv
// Game-flow FSM for pong_2p: tracks balls and scores, picks the winner and
// drives the text-overlay enables and the graphics freeze flag.
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int unsigned BALLS       = 9,
  parameter int unsigned WIN_SCORE   = 5,
  parameter int unsigned TIMER_TICKS = 120
) (
  input  logic             clk,
  input  logic             reset_n,
  pong_game_ctrl_if.slave  bus
);

  state_t     state;
  logic       start_q;
  logic       start_rise;
  logic       timer_load;
  logic       timer_up;
  logic       l_hit;
  logic       r_hit;
  logic       any_hit;
  logic [3:0] next_left;
  logic [3:0] next_right;
  logic [3:0] next_ball;
  logic       game_end;

  pong_timer #(.TIMER_TICKS(TIMER_TICKS)) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (timer_load),
    .tick     (bus.refresh_tick),
    .timer_up (timer_up)
  );

  // Simultaneous misses cancel out and only trigger a replay.
  always_comb begin
    start_rise = bus.start_btn & ~start_q;
    l_hit      = bus.right_miss & ~bus.left_miss;
    r_hit      = bus.left_miss & ~bus.right_miss;
    any_hit    = l_hit | r_hit;
    next_left  = bus.left_score + {3'b000, l_hit};
    next_right = bus.right_score + {3'b000, r_hit};
    next_ball  = bus.ball - {3'b000, any_hit};
    game_end   = (next_left == 4'(WIN_SCORE)) || (next_right == 4'(WIN_SCORE)) ||
                 (next_ball == '0);
    timer_load = (state == PLAY) && (bus.left_miss || bus.right_miss);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state           <= NEWGAME;
      start_q         <= 1'b0;
      bus.ball        <= 4'(BALLS);
      bus.left_score  <= '0;
      bus.right_score <= '0;
      bus.winner      <= WIN_BLUE;
      bus.text_en     <= text_mask(NEWGAME);
      bus.gra_still   <= 1'b1;
    end else begin
      start_q <= bus.start_btn;
      case (state)
        NEWGAME: begin
          bus.ball        <= 4'(BALLS);
          bus.left_score  <= '0;
          bus.right_score <= '0;
          if (start_rise) begin
            state         <= PLAY;
            bus.text_en   <= text_mask(PLAY);
            bus.gra_still <= 1'b0;
          end
        end
        PLAY: begin
          if (bus.left_miss || bus.right_miss) begin
            bus.left_score  <= next_left;
            bus.right_score <= next_right;
            bus.ball        <= next_ball;
            bus.gra_still   <= 1'b1;
            if (any_hit && game_end) begin
              state       <= OVER;
              bus.winner  <= (next_right > next_left) ? WIN_RED : WIN_BLUE;
              bus.text_en <= text_mask(OVER);
            end else begin
              state       <= NEWBALL;
              bus.text_en <= text_mask(NEWBALL);
            end
          end
        end
        NEWBALL: begin
          if (timer_up) begin
            state         <= PLAY;
            bus.text_en   <= text_mask(PLAY);
            bus.gra_still <= 1'b0;
          end
        end
        OVER: begin
          if (timer_up) begin
            state           <= NEWGAME;
            bus.ball        <= 4'(BALLS);
            bus.left_score  <= '0;
            bus.right_score <= '0;
            bus.text_en     <= text_mask(NEWGAME);
            bus.gra_still   <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl: expected output snapshots are queued as
// stimulus is applied and compared against the DUT on the falling edge.
module tb_pong_game_ctrl;
  import pong_pkg::*;

  localparam logic [3:0] T_NG   = 4'b1110;
  localparam logic [3:0] T_PLAY = 4'b1000;
  localparam logic [3:0] T_OVER = 4'b1001;

  typedef struct {
    string       tag;
    logic [17:0] val;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n;
  exp_t sb[$];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 clk = ~clk;

  pong_game_ctrl_if bus();

  pong_game_ctrl #(
    .BALLS       (9),
    .WIN_SCORE   (5),
    .TIMER_TICKS (120)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  function automatic logic [17:0] pk(int b, int l, int r, logic w, logic [3:0] t, logic g);
    return {4'(b), 4'(l), 4'(r), w, t, g};
  endfunction

  function automatic logic [17:0] observe();
    return {bus.ball, bus.left_score, bus.right_score, bus.winner, bus.text_en, bus.gra_still};
  endfunction

  task automatic cycle();
    @(negedge clk);
  endtask

  task automatic push(string tag, logic [17:0] v);
    sb.push_back('{tag, v});
  endtask

  task automatic check_pop();
    exp_t        e;
    logic [17:0] obs;
    n_checks++;
    if (sb.size() == 0) begin
      $error("FAIL scoreboard_empty: observed 0 entries expected >=1");
    end else begin
      e   = sb.pop_front();
      obs = observe();
      assert (obs === e.val) n_pass++;
      else $error("FAIL %s: observed %h expected %h {ball,ls,rs,win,txt,still}", e.tag, obs, e.val);
    end
  endtask

  task automatic step(string tag, logic [17:0] v);
    push(tag, v);
    cycle();
    check_pop();
  endtask

  task automatic check_timer_zero(string tag);
    n_checks++;
    assert (dut.u_timer.count === '0) n_pass++;
    else $error("FAIL %s: observed timer %0d expected 0", tag, dut.u_timer.count);
  endtask

  task automatic miss(logic l, logic r, logic t, string tag, logic [17:0] v);
    bus.left_miss    = l;
    bus.right_miss   = r;
    bus.refresh_tick = t;
    push(tag, v);
    cycle();
    bus.left_miss    = 1'b0;
    bus.right_miss   = 1'b0;
    bus.refresh_tick = 1'b0;
    check_pop();
  endtask

  // 119 ticks leave the pause running; the 120th ends it one cycle later.
  task automatic run_timer(string tag, logic [17:0] during, logic [17:0] after);
    for (int i = 0; i < 119; i++) begin
      bus.refresh_tick = 1'b1;
      cycle();
      bus.refresh_tick = 1'b0;
      cycle();
    end
    push({tag, "_119"}, during);
    check_pop();
    bus.refresh_tick = 1'b1;
    step({tag, "_120"}, during);
    bus.refresh_tick = 1'b0;
    step({tag, "_done"}, after);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n          = 1'b0;
    bus.refresh_tick = 1'b0;
    bus.start_btn    = 1'b0;
    bus.left_miss    = 1'b0;
    bus.right_miss   = 1'b0;
    cycle();
    step("reset", pk(9, 0, 0, 0, T_NG, 1));
    check_timer_zero("reset_timer");
    reset_n = 1'b1;
    step("idle_ng", pk(9, 0, 0, 0, T_NG, 1));

    // Held start produces exactly one game start.
    bus.start_btn = 1'b1;
    step("start", pk(9, 0, 0, 0, T_PLAY, 0));
    step("start_held1", pk(9, 0, 0, 0, T_PLAY, 0));
    step("start_held2", pk(9, 0, 0, 0, T_PLAY, 0));
    bus.start_btn = 1'b0;
    step("start_release", pk(9, 0, 0, 0, T_PLAY, 0));

    miss(0, 1, 0, "r1", pk(8, 1, 0, 0, T_PLAY, 1));
    miss(1, 0, 0, "nb_ign_l", pk(8, 1, 0, 0, T_PLAY, 1));
    miss(0, 1, 0, "nb_ign_r", pk(8, 1, 0, 0, T_PLAY, 1));
    bus.start_btn = 1'b1;
    step("nb_ign_start", pk(8, 1, 0, 0, T_PLAY, 1));
    bus.start_btn = 1'b0;
    cycle();
    run_timer("nb1", pk(8, 1, 0, 0, T_PLAY, 1), pk(8, 1, 0, 0, T_PLAY, 0));

    // Tick coincident with the load edge must not shorten the pause.
    miss(1, 0, 1, "l1_tick", pk(7, 1, 1, 0, T_PLAY, 1));
    run_timer("nb2", pk(7, 1, 1, 0, T_PLAY, 1), pk(7, 1, 1, 0, T_PLAY, 0));
    miss(1, 1, 0, "both", pk(7, 1, 1, 0, T_PLAY, 1));
    run_timer("nb3", pk(7, 1, 1, 0, T_PLAY, 1), pk(7, 1, 1, 0, T_PLAY, 0));
    miss(0, 1, 0, "r2", pk(6, 2, 1, 0, T_PLAY, 1));
    run_timer("nb4", pk(6, 2, 1, 0, T_PLAY, 1), pk(6, 2, 1, 0, T_PLAY, 0));
    miss(0, 1, 0, "r3", pk(5, 3, 1, 0, T_PLAY, 1));
    run_timer("nb5", pk(5, 3, 1, 0, T_PLAY, 1), pk(5, 3, 1, 0, T_PLAY, 0));
    miss(0, 1, 0, "r4", pk(4, 4, 1, 0, T_PLAY, 1));
    run_timer("nb6", pk(4, 4, 1, 0, T_PLAY, 1), pk(4, 4, 1, 0, T_PLAY, 0));
    miss(0, 1, 0, "r5_over", pk(3, 5, 1, 0, T_OVER, 1));

    // Start held across OVER->NEWGAME must not restart play.
    bus.start_btn = 1'b1;
    run_timer("over1", pk(3, 5, 1, 0, T_OVER, 1), pk(9, 0, 0, 0, T_NG, 1));
    step("held_ng1", pk(9, 0, 0, 0, T_NG, 1));
    step("held_ng2", pk(9, 0, 0, 0, T_NG, 1));
    bus.start_btn = 1'b0;
    step("release_ng", pk(9, 0, 0, 0, T_NG, 1));
    bus.start_btn = 1'b1;
    step("restart", pk(9, 0, 0, 0, T_PLAY, 0));
    bus.start_btn = 1'b0;
    cycle();

    miss(1, 0, 0, "g2_l1", pk(8, 0, 1, 0, T_PLAY, 1));
    run_timer("g2nb1", pk(8, 0, 1, 0, T_PLAY, 1), pk(8, 0, 1, 0, T_PLAY, 0));
    miss(0, 1, 0, "g2_r1", pk(7, 1, 1, 0, T_PLAY, 1));
    run_timer("g2nb2", pk(7, 1, 1, 0, T_PLAY, 1), pk(7, 1, 1, 0, T_PLAY, 0));
    miss(1, 0, 0, "g2_l2", pk(6, 1, 2, 0, T_PLAY, 1));
    run_timer("g2nb3", pk(6, 1, 2, 0, T_PLAY, 1), pk(6, 1, 2, 0, T_PLAY, 0));
    miss(0, 1, 0, "g2_r2", pk(5, 2, 2, 0, T_PLAY, 1));
    run_timer("g2nb4", pk(5, 2, 2, 0, T_PLAY, 1), pk(5, 2, 2, 0, T_PLAY, 0));
    miss(0, 1, 0, "g2_r3", pk(4, 3, 2, 0, T_PLAY, 1));
    for (int i = 0; i < 5; i++) begin
      bus.refresh_tick = 1'b1;
      cycle();
      bus.refresh_tick = 1'b0;
      cycle();
    end
    reset_n = 1'b0;
    push("midgame_reset", pk(9, 0, 0, 0, T_NG, 1));
    cycle();
    reset_n = 1'b1;
    check_pop();
    check_timer_zero("midgame_reset_timer");
    step("post_reset_idle", pk(9, 0, 0, 0, T_NG, 1));

    // Red reaches WIN_SCORE first.
    bus.start_btn = 1'b1;
    step("g3_start", pk(9, 0, 0, 0, T_PLAY, 0));
    bus.start_btn = 1'b0;
    cycle();
    miss(1, 0, 0, "g3_l1", pk(8, 0, 1, 0, T_PLAY, 1));
    run_timer("g3nb1", pk(8, 0, 1, 0, T_PLAY, 1), pk(8, 0, 1, 0, T_PLAY, 0));
    miss(1, 0, 0, "g3_l2", pk(7, 0, 2, 0, T_PLAY, 1));
    run_timer("g3nb2", pk(7, 0, 2, 0, T_PLAY, 1), pk(7, 0, 2, 0, T_PLAY, 0));
    miss(1, 0, 0, "g3_l3", pk(6, 0, 3, 0, T_PLAY, 1));
    run_timer("g3nb3", pk(6, 0, 3, 0, T_PLAY, 1), pk(6, 0, 3, 0, T_PLAY, 0));
    miss(1, 0, 0, "g3_l4", pk(5, 0, 4, 0, T_PLAY, 1));
    run_timer("g3nb4", pk(5, 0, 4, 0, T_PLAY, 1), pk(5, 0, 4, 0, T_PLAY, 0));
    miss(1, 0, 0, "g3_l5_over", pk(4, 0, 5, 1, T_OVER, 1));
    step("g3_over_hold", pk(4, 0, 5, 1, T_OVER, 1));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pong_game_ctrl.md
Name: pong_game_ctrl

Overview:
- Two-player game-flow controller for pong_2p. Sits directly upstream of the text overlay stage and drives every value it renders: balls remaining, left/right scores, winner, and the per-region text enables.
- Consumes miss pulses from the graphics stage, a start button and a once-per-frame refresh tick.
- Also tells the graphics stage when to freeze the ball and paddles.

Parameters:
- BALLS, 9: balls per game. Must be odd and ≤9, so every score fits one digit and a tie is impossible.
- WIN_SCORE, 5: score that ends the game early. Must be ≤ (BALLS+1)/2.
- TIMER_TICKS, 120: refresh ticks to wait in NEWBALL and OVER (2 s at 60 Hz).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous, active-low reset.
- refresh_tick  in  1  one-cycle pulse per frame.
- start_btn  in  1  level; only a rising edge is used.
- left_miss  in  1  one-cycle pulse: ball passed the left wall. Right (Red) player scores.
- right_miss  in  1  one-cycle pulse: ball passed the right wall. Left (Blue) player scores.
- ball  out  4  balls remaining, 0..BALLS.
- left_score  out  4  Blue score, 0..9.
- right_score  out  4  Red score, 0..9.
- winner  out  1  0 = Blue (left) wins, 1 = Red (right) wins. Valid in OVER only.
- text_en  out  4  {score, logo, rule, over} region enables.
- gra_still  out  1  1 = freeze ball and paddles.

Behaviour:
- Interface: one clock, clk. Reset reset_n is synchronous and active-low. All outputs are registered.
- Reset values: state NEWGAME, ball = BALLS, scores = 0, winner = 0, text_en = 4'b1110, gra_still = 1, timer = 0, start-edge register = 0.
- Reset mid-game is honoured on the next clk edge from any state and produces exactly the reset values.
- Start detection: start_q registers start_btn. start_rise = start_btn & ~start_q.

States and transitions:
- NEWGAME
  - text_en = 1110, gra_still = 1. Scores = 0, ball = BALLS.
  - start_rise → PLAY on the next edge.
- PLAY
  - text_en = 1000, gra_still = 0.
  - On right_miss only: left_score+1, ball−1.
  - On left_miss only: right_score+1, ball−1.
  - Updated values are visible the cycle after the pulse. The next state is decided in the same edge using the updated values.
  - If the updated score equals WIN_SCORE, or the updated ball equals 0 → OVER.
  - Otherwise → NEWBALL.
  - Both misses in the same cycle: no score change, no decrement, → NEWBALL (replay).
- NEWBALL
  - text_en = 1000, gra_still = 1.
  - Timer is loaded with TIMER_TICKS on entry and decrements on each refresh_tick.
  - When the timer reaches 0 → PLAY. start_btn is ignored.
- OVER
  - text_en = 1001, gra_still = 1.
  - winner is latched on entry: 1 if right_score > left_score, else 0.
  - Timer is loaded on entry. At 0 → NEWGAME, which clears scores and ball on that edge.

Input and arithmetic rules:
- Miss pulses are ignored outside PLAY.
- start_rise is ignored outside NEWGAME.
- A button held through OVER→NEWGAME does not restart the game; a new press is required.
- Scores and ball never wrap. Parameter limits guarantee this; saturating logic is not needed.
- Values < 10, so binary equals BCD, which the text stage consumes directly.
- A refresh_tick that coincides with the timer-load cycle is not counted.

Decomposition:
- Package pong_pkg holds:
  - state encoding: NEWGAME = 2'b00, PLAY = 2'b01, NEWBALL = 2'b10, OVER = 2'b11;
  - text_en bit indices: SCORE = 3, LOGO = 2, RULE = 1, OVER = 0;
  - winner codes: BLUE = 0, RED = 1.
- Sub-module pong_timer contains the down-counter:
  - ports: clk, reset_n, load, tick, timer_up;
  - width = $clog2(TIMER_TICKS+1);
  - loads TIMER_TICKS when load = 1; timer_up = (count == 0).

Test Plan:
- Reset, then start_btn held 3 cycles → PLAY one cycle after the rise; text_en 1110→1000, gra_still 1→0. No second start occurs.
- In PLAY, right_miss pulse → next cycle left_score = 1, ball = 8, NEWBALL. After 120 refresh_ticks → PLAY.
- Four right_miss plus one left_miss (across NEWBALL waits), final one a right_miss → left_score = 5, right_score = 1, OVER, winner = 0, text_en = 1001.
- left_miss and right_miss in the same cycle → scores unchanged, ball unchanged, NEWBALL. Pulses sent during NEWBALL → ignored.
- reset_n low for one cycle during NEWBALL with scores 3:2 → next cycle NEWGAME, scores 0:0, ball = 9, timer = 0.
- OVER timer expires while start_btn is held high → NEWGAME, scores cleared, no PLAY until start_btn falls and rises again.
